datamover_wr_ctrl: RTL and testbench

- Command/status controller for the AXI DataMover S2MM (stream-to-memory) channel; the write-side counterpart of the MM2S read command controller.
- On a start edge it splits a byte region into CHUNK-sized write commands, tags each one, and retires the matching S2MM status beats.
- It flags errors and pulses finish once every byte is written.
- Sits between the PS/register-side control (start, address, size) and the DataMover S2MM CMD/STS AXI-Stream ports.

---
 rtl/datamover_pkg.sv | 42 ++++
 rtl/dm_cmd_fifo.sv | 53 +++++
 rtl/datamover_wr_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_datamover_wr_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datamover_pkg.sv
// Shared definitions for the DataMover S2MM write controller:
// command field layout, status bits, FSM encoding, command builder.
package datamover_pkg;

  localparam int CMD_W     = 104;
  localparam int TAG_LSB   = 96;
  localparam int TAG_W     = 4;
  localparam int SADDR_LSB = 32;
  localparam int SADDR_W   = 64;
  localparam int EOF_BIT   = 30;
  localparam int TYPE_BIT  = 23;
  localparam int BTT_W     = 23;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;
  localparam int STS_TAG_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wr_state_e;

  function automatic logic [CMD_W-1:0] build_cmd(
    input logic [TAG_W-1:0]   tag,
    input logic [SADDR_W-1:0] saddr,
    input logic [BTT_W-1:0]   btt
  );
    logic [CMD_W-1:0] c;
    c = '0;
    c[TAG_LSB +: TAG_W]     = tag;
    c[SADDR_LSB +: SADDR_W] = saddr;
    c[EOF_BIT]              = 1'b1;
    c[TYPE_BIT]             = 1'b1;
    c[BTT_W-1:0]            = btt;
    return c;
  endfunction

endpackage

// File: rtl/dm_cmd_fifo.sv
// Small FIFO of in-flight commands {tag, btt}, pushed on command
// accept and popped when the matching status beat retires.
module dm_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (do_pop)  rp <= (rp == LAST) ? '0 : rp + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/datamover_wr_ctrl.sv
// S2MM command/status controller: splits a byte region into
// CHUNK-sized tagged write commands and retires their status beats.
module datamover_wr_ctrl #(
  parameter int CHUNK       = 4096,
  parameter int MAX_OUTS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          axis_clk,
  input  logic          axis_rst,
  input  logic [63:0]   ddr_address,
  input  logic [63:0]   data_size,
  input  logic          start,
  output logic          finish,
  output logic          busy,
  output logic          error,
  output logic [103:0]  S_AXIS_S2MM_CMD_tdata,
  output logic          S_AXIS_S2MM_CMD_tvalid,
  input  logic          S_AXIS_S2MM_CMD_tready,
  input  logic [7:0]    M_AXIS_S2MM_STS_tdata,
  input  logic          M_AXIS_S2MM_STS_tkeep,
  input  logic          M_AXIS_S2MM_STS_tlast,
  input  logic          M_AXIS_S2MM_STS_tvalid,
  output logic          M_AXIS_S2MM_STS_tready,
  output logic [63:0]   wr_addr,
  output logic [63:0]   done_cnt,
  output logic [1:0]    state
);
  import datamover_pkg::*;

  localparam logic [BTT_W-1:0] CHUNK_BTT = BTT_W'(CHUNK);
  localparam logic [3:0]       MAX_O     = 4'(MAX_OUTS);
  localparam int               FW        = TAG_W + BTT_W;

  logic [SYNC_STAGES-1:0] start_sh;
  logic [63:0]            addr_sh [SYNC_STAGES];
  logic [63:0]            size_sh [SYNC_STAGES];
  logic                   start_d;
  logic                   start_edge;
  logic [63:0]            size_s;

  wr_state_e        st_q;
  wr_state_e        st_d;
  logic [63:0]      addr_q;
  logic [63:0]      rem_q;
  logic [63:0]      done_q;
  logic [3:0]       tag_q;
  logic [3:0]       outs_q;
  logic             err_q;
  logic             rdy_q;
  logic [BTT_W-1:0] btt;
  logic             last_cmd;
  logic             go;
  logic             accept;
  logic             retire;
  logic             drop;
  logic             bad_sts;
  logic [FW-1:0]    head;
  logic             f_full;
  logic             f_empty;
  logic             unused_sts;

  assign size_s     = size_sh[SYNC_STAGES-1];
  assign start_edge = start_sh[SYNC_STAGES-1] && !start_d;
  assign go         = start_edge && (st_q == IDLE);

  assign btt = (rem_q < 64'(CHUNK)) ? rem_q[BTT_W-1:0]
                                    : CHUNK_BTT;
  assign last_cmd = (rem_q <= 64'(CHUNK));

  assign accept = S_AXIS_S2MM_CMD_tvalid
               && S_AXIS_S2MM_CMD_tready;
  assign retire = M_AXIS_S2MM_STS_tvalid && rdy_q
               && M_AXIS_S2MM_STS_tlast
               && (outs_q != '0) && !f_empty;
  assign drop   = M_AXIS_S2MM_STS_tvalid && rdy_q
               && (outs_q == '0);
  assign bad_sts = retire
    && ((head[FW-1:BTT_W] != M_AXIS_S2MM_STS_tdata[3:0])
     || !M_AXIS_S2MM_STS_tdata[STS_OKAY]);

  assign S_AXIS_S2MM_CMD_tdata = S_AXIS_S2MM_CMD_tvalid
    ? build_cmd(tag_q, addr_q, btt) : '0;

  assign M_AXIS_S2MM_STS_tready = rdy_q;
  assign wr_addr  = addr_q;
  assign done_cnt = done_q;
  assign error    = err_q;
  assign state    = st_q;

  assign unused_sts = &{1'b0, M_AXIS_S2MM_STS_tkeep,
                        M_AXIS_S2MM_STS_tdata[6:4]};

  dm_cmd_fifo #(
    .DEPTH (MAX_OUTS),
    .W     (FW)
  ) u_fifo (
    .clk   (axis_clk),
    .rst   (axis_rst),
    .push  (accept),
    .din   ({tag_q, btt}),
    .pop   (retire),
    .dout  (head),
    .full  (f_full),
    .empty (f_empty)
  );

  // bring start and the job parameters into this clock domain
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      start_sh <= '0;
      start_d  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sh[i] <= '0;
        size_sh[i] <= '0;
      end
    end else begin
      start_sh[0] <= start;
      addr_sh[0]  <= ddr_address;
      size_sh[0]  <= data_size;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        start_sh[i] <= start_sh[i-1];
        addr_sh[i]  <= addr_sh[i-1];
        size_sh[i]  <= size_sh[i-1];
      end
      start_d <= start_sh[SYNC_STAGES-1];
    end
  end

  // next state and handshake/status outputs
  always_comb begin
    st_d   = st_q;
    finish = 1'b0;
    busy   = 1'b0;
    S_AXIS_S2MM_CMD_tvalid = 1'b0;
    unique case (1'b1)
      (st_q == IDLE): begin
        if (start_edge)
          st_d = (size_s != '0) ? ISSUE : DONE;
      end
      (st_q == ISSUE): begin
        busy = 1'b1;
        S_AXIS_S2MM_CMD_tvalid = (outs_q < MAX_O)
                              && !f_full;
        if (S_AXIS_S2MM_CMD_tvalid
            && S_AXIS_S2MM_CMD_tready && last_cmd)
          st_d = DRAIN;
      end
      (st_q == DRAIN): begin
        busy = 1'b1;
        if (outs_q == '0) st_d = DONE;
      end
      (st_q == DONE): begin
        finish = 1'b1;
        st_d   = IDLE;
      end
      default: ;
    endcase
  end

  // job state: address, remaining bytes, tags, in-flight count
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      st_q   <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      done_q <= '0;
      tag_q  <= '0;
      outs_q <= '0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      rdy_q <= 1'b1;
      if (go) begin
        addr_q <= addr_sh[SYNC_STAGES-1];
        rem_q  <= size_s;
        tag_q  <= '0;
      end else if (accept) begin
        addr_q <= addr_q + 64'(btt);
        rem_q  <= rem_q - 64'(btt);
        tag_q  <= tag_q + 1'b1;
      end
      if (go)
        done_q <= '0;
      else if (retire)
        done_q <= done_q + 64'(head[BTT_W-1:0]);
      if (accept && !retire)      outs_q <= outs_q + 1'b1;
      else if (retire && !accept) outs_q <= outs_q - 1'b1;
      err_q <= (go ? 1'b0 : err_q) | bad_sts | drop;
    end
  end

endmodule

// File: tb/tb_datamover_wr_ctrl.sv
// Directed bench for datamover_wr_ctrl with a status responder
// that echoes each accepted command's tag after a fixed delay.
module tb_datamover_wr_ctrl;

  localparam int DLY = 5;

  logic         axis_clk = 1'b0;
  logic         axis_rst;
  logic [63:0]  ddr_address;
  logic [63:0]  data_size;
  logic         start;
  logic         finish;
  logic         busy;
  logic         error;
  logic [103:0] cmd_tdata;
  logic         cmd_tvalid;
  logic         cmd_tready;
  logic [7:0]   sts_tdata;
  logic         sts_tkeep;
  logic         sts_tlast;
  logic         sts_tvalid;
  logic         sts_tready;
  logic [63:0]  wr_addr;
  logic [63:0]  done_cnt;
  logic [1:0]   state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fin_cnt = 0;
  int sts_idx = 0;
  int bad_idx = -1;
  bit sts_en = 1'b1;
  bit stray_req = 1'b0;
  int due_q[$];
  logic [3:0] tag_q[$];
  logic [103:0] cmds[$];

  always #5 axis_clk = ~axis_clk;

  datamover_wr_ctrl dut (
    .axis_clk               (axis_clk),
    .axis_rst               (axis_rst),
    .ddr_address            (ddr_address),
    .data_size              (data_size),
    .start                  (start),
    .finish                 (finish),
    .busy                   (busy),
    .error                  (error),
    .S_AXIS_S2MM_CMD_tdata  (cmd_tdata),
    .S_AXIS_S2MM_CMD_tvalid (cmd_tvalid),
    .S_AXIS_S2MM_CMD_tready (cmd_tready),
    .M_AXIS_S2MM_STS_tdata  (sts_tdata),
    .M_AXIS_S2MM_STS_tkeep  (sts_tkeep),
    .M_AXIS_S2MM_STS_tlast  (sts_tlast),
    .M_AXIS_S2MM_STS_tvalid (sts_tvalid),
    .M_AXIS_S2MM_STS_tready (sts_tready),
    .wr_addr                (wr_addr),
    .done_cnt               (done_cnt),
    .state                  (state)
  );

  // command monitor and status scheduling
  always @(posedge axis_clk) begin
    cyc++;
    if (finish) fin_cnt++;
    if (axis_rst) begin
      due_q.delete();
      tag_q.delete();
    end else if (cmd_tvalid && cmd_tready) begin
      cmds.push_back(cmd_tdata);
      due_q.push_back(cyc + DLY);
      tag_q.push_back(cmd_tdata[99:96]);
    end
  end

  // status beat driver
  always @(negedge axis_clk) begin
    logic [3:0] t;
    int d;
    sts_tvalid = 1'b0;
    sts_tlast  = 1'b0;
    sts_tdata  = 8'h00;
    if (stray_req) begin
      sts_tvalid = 1'b1;
      sts_tlast  = 1'b1;
      sts_tdata  = 8'h80;
      stray_req  = 1'b0;
    end else if (sts_en && due_q.size() > 0
                 && due_q[0] <= cyc) begin
      d = due_q.pop_front();
      t = tag_q.pop_front();
      sts_tdata  = (sts_idx == bad_idx) ? {4'h4, t}
                                        : {4'h8, t};
      sts_tvalid = 1'b1;
      sts_tlast  = 1'b1;
      sts_idx++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [103:0] exp_cmd(
    input logic [3:0]  tag,
    input logic [63:0] a,
    input logic [22:0] b
  );
    return {4'h0, tag, a, 1'b0, 1'b1,
            6'h00, 1'b1, b};
  endfunction

  task automatic chk(input string name,
                     input logic [103:0] obs,
                     input logic [103:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge axis_clk);
  endtask

  task automatic begin_job(input logic [63:0] a,
                           input logic [63:0] s);
    ddr_address = a;
    data_size   = s;
    cmds.delete();
    tick(1);
    start = 1'b1;
  endtask

  task automatic end_job();
    start = 1'b0;
    tick(4);
  endtask

  task automatic wait_tvalid(input string name);
    int n;
    n = 0;
    while (!cmd_tvalid && n < 50) begin
      tick(1);
      n++;
    end
    chk(name, cmd_tvalid, 1);
  endtask

  task automatic wait_finish(input string name,
                             output int lat);
    int f0;
    bit got;
    f0  = fin_cnt;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      tick(1);
      lat++;
      if (finish) got = 1'b1;
    end
    chk(name, got, 1);
    tick(1);
    chk({name, "_pulse"}, fin_cnt - f0, 1);
  endtask

  initial begin
    int lat;
    logic [103:0] first;
    bit stable;
    logic [63:0] b;

    axis_rst    = 1'b1;
    start       = 1'b0;
    ddr_address = '0;
    data_size   = '0;
    cmd_tready  = 1'b0;
    sts_tkeep   = 1'b1;
    tick(3);
    chk("rst_state",  state, 0);
    chk("rst_addr",   wr_addr, 0);
    chk("rst_done",   done_cnt, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_fin",    finish, 0);
    chk("rst_err",    error, 0);
    chk("rst_tvalid", cmd_tvalid, 0);
    chk("rst_tdata",  cmd_tdata, 0);
    chk("rst_stsrdy", sts_tready, 0);
    axis_rst = 1'b0;
    tick(2);

    // basic three-command job
    b = 64'h1000_0000;
    cmd_tready = 1'b1;
    begin_job(b, 64'h3000);
    wait_tvalid("j1_tvalid");
    chk("j1_busy", busy, 1);
    wait_finish("j1_finish", lat);
    chk("j1_ncmd", cmds.size(), 3);
    chk("j1_cmd0", cmds[0], exp_cmd(0, b, 23'h1000));
    chk("j1_cmd1", cmds[1],
        exp_cmd(1, b + 64'h1000, 23'h1000));
    chk("j1_cmd2", cmds[2],
        exp_cmd(2, b + 64'h2000, 23'h1000));
    chk("j1_done", done_cnt, 64'h3000);
    chk("j1_err", error, 0);
    chk("j1_idle", state, 0);
    end_job();

    // remainder chunk
    b = 64'h2000_0000;
    begin_job(b, 64'h2100);
    wait_finish("j2_finish", lat);
    chk("j2_ncmd", cmds.size(), 3);
    chk("j2_cmd1", cmds[1],
        exp_cmd(1, b + 64'h1000, 23'h1000));
    chk("j2_cmd2", cmds[2],
        exp_cmd(2, b + 64'h2000, 23'h100));
    chk("j2_addr", wr_addr, b + 64'h2100);
    chk("j2_done", done_cnt, 64'h2100);
    end_job();

    // back-pressure, then outstanding limit
    b = 64'h3000_0000;
    cmd_tready = 1'b0;
    sts_en = 1'b0;
    begin_job(b, 64'h8000);
    wait_tvalid("j3_tvalid");
    first = cmd_tdata;
    chk("j3_first", first, exp_cmd(0, b, 23'h1000));
    stable = 1'b1;
    repeat (10) begin
      tick(1);
      if (cmd_tdata !== first || !cmd_tvalid
          || wr_addr !== b) stable = 1'b0;
    end
    chk("j3_stable", stable, 1);
    chk("j3_nostall", cmds.size(), 0);
    cmd_tready = 1'b1;
    tick(20);
    chk("j3_maxouts", cmds.size(), 4);
    chk("j3_tv_low", cmd_tvalid, 0);
    chk("j3_issue", state, 1);
    sts_en = 1'b1;
    wait_finish("j3_finish", lat);
    chk("j3_ncmd", cmds.size(), 8);
    chk("j3_cmd7", cmds[7],
        exp_cmd(7, b + 64'h7000, 23'h1000));
    chk("j3_done", done_cnt, 64'h8000);
    chk("j3_err", error, 0);
    end_job();

    // bad second status
    bad_idx = sts_idx + 1;
    begin_job(64'h4000_0000, 64'h3000);
    wait_finish("j4_finish", lat);
    chk("j4_err", error, 1);
    tick(3);
    chk("j4_sticky", error, 1);
    end_job();
    bad_idx = -1;
    begin_job(64'h5000_0000, 64'h1000);
    wait_tvalid("j4b_tvalid");
    chk("j4b_clr", error, 0);
    wait_finish("j4b_finish", lat);
    chk("j4b_err", error, 0);
    chk("j4b_done", done_cnt, 64'h1000);
    end_job();

    // zero-size job
    begin_job(64'h5555_0000, 64'h0);
    wait_finish("j5_finish", lat);
    chk("j5_lat", (lat >= 2 && lat <= 6), 1);
    chk("j5_ncmd", cmds.size(), 0);
    chk("j5_done", done_cnt, 0);
    end_job();

    // start re-toggled while busy
    b = 64'h6000_0000;
    sts_en = 1'b0;
    begin_job(b, 64'h3000);
    tick(15);
    chk("j6_ncmd", cmds.size(), 3);
    chk("j6_drain", state, 2);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(6);
    chk("j6_ignored", state, 2);
    chk("j6_addr", wr_addr, b + 64'h3000);
    chk("j6_ncmd2", cmds.size(), 3);
    sts_en = 1'b1;
    wait_finish("j6_finish", lat);
    chk("j6_done", done_cnt, 64'h3000);
    end_job();

    // reset mid-job
    b = 64'h7000_0000;
    cmd_tready = 1'b0;
    sts_en = 1'b0;
    begin_job(b, 64'h3000);
    wait_tvalid("j7_tvalid");
    cmd_tready = 1'b1;
    tick(1);
    cmd_tready = 1'b0;
    tick(2);
    chk("j7_ncmd", cmds.size(), 1);
    chk("j7_addr", wr_addr, b + 64'h1000);
    start = 1'b0;
    axis_rst = 1'b1;
    #1;
    chk("j7_state", state, 0);
    chk("j7_addr0", wr_addr, 0);
    chk("j7_done0", done_cnt, 0);
    chk("j7_busy0", busy, 0);
    chk("j7_tv0", cmd_tvalid, 0);
    chk("j7_td0", cmd_tdata, 0);
    chk("j7_err0", error, 0);
    tick(2);
    axis_rst = 1'b0;
    tick(2);
    stray_req = 1'b1;
    tick(3);
    chk("j7_stray", error, 1);
    chk("j7_idle", state, 0);
    chk("j7_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
